// File: rtl/ks_pkg.sv
// Shared definitions for the Kogge-Stone subtractor: prefix operator,
// level-count derivation and the pipeline stage payload.
package ks_pkg;

  // Payload fields are sized for the widest legal operand; narrower
  // instances leave the upper bits at zero.
  localparam int KS_MAX_WIDTH = 64;

  function automatic int ks_levels(input int width);
    return $clog2(width);
  endfunction

  // (g,p) o (g',p') = (g | p&g', p&p'), returned as {g, p}
  function automatic logic [1:0] ks_dot(input logic g_hi, input logic p_hi,
                                        input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

  typedef struct packed {
    logic [KS_MAX_WIDTH-1:0] g;
    logic [KS_MAX_WIDTH-1:0] p;
    logic [KS_MAX_WIDTH-1:0] p0;
    logic                    c0;
    logic                    a_msb;
    logic                    b_msb;
  } ks_stage_t;

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level combining each bit with the
// bit DIST positions below it.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < DIST) begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end else begin : g_dot
      logic [1:0] gp;
      assign gp       = ks_dot(g_in[i], p_in[i], g_in[i-DIST], p_in[i-DIST]);
      assign g_out[i] = gp[1];
      assign p_out[i] = gp[0];
    end
  end

endmodule

// File: rtl/ks_sub32_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor: diff = a - b - b_in,
// computed as a + ~b + ~b_in with a radix-2 parallel-prefix carry tree.
module ks_sub32_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = ks_levels(WIDTH);
  // Distances 1,2,4 in stage 2; everything wider in stage 3.
  localparam int SPLIT  = (LEVELS < 3) ? LEVELS : 3;

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high. A stage loads when it is empty or its content moves on this edge,
  // so ready ripples combinationally from out_ready back to in_ready.
  logic v1, v2, v3;
  logic en1, en2, en3;

  assign en3      = ~v3 | out_ready;
  assign en2      = ~v2 | en3;
  assign en1      = ~v1 | en2;
  assign in_ready = en1;
  assign out_valid = v3;

  ks_stage_t s1, s2, s1_next, s2_next;

  always_comb begin
    s1_next                = '0;
    s1_next.g[WIDTH-1:0]   = a & ~b;
    s1_next.p[WIDTH-1:0]   = a ^ ~b;
    s1_next.p0[WIDTH-1:0]  = a ^ ~b;
    s1_next.c0             = ~b_in;
    s1_next.a_msb          = a[WIDTH-1];
    s1_next.b_msb          = b[WIDTH-1];
  end

  logic [WIDTH-1:0] lvl_g [0:LEVELS];
  logic [WIDTH-1:0] lvl_p [0:LEVELS];

  // Carry-in is folded into bit 0 so every G[i] already includes it.
  assign lvl_g[0] = {s1.g[WIDTH-1:1], s1.g[0] | (s1.p[0] & s1.c0)};
  assign lvl_p[0] = s1.p[WIDTH-1:0];

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    logic [WIDTH-1:0] g_src, p_src;
    if (l == SPLIT) begin : g_from_reg
      assign g_src = s2.g[WIDTH-1:0];
      assign p_src = s2.p[WIDTH-1:0];
    end else begin : g_from_chain
      assign g_src = lvl_g[l];
      assign p_src = lvl_p[l];
    end
    ks_prefix_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << l)
    ) u_level (
      .g_in  (g_src),
      .p_in  (p_src),
      .g_out (lvl_g[l+1]),
      .p_out (lvl_p[l+1])
    );
  end

  always_comb begin
    s2_next               = '0;
    s2_next.g[WIDTH-1:0]  = lvl_g[SPLIT];
    s2_next.p[WIDTH-1:0]  = lvl_p[SPLIT];
    s2_next.p0            = s1.p0;
    s2_next.c0            = s1.c0;
    s2_next.a_msb         = s1.a_msb;
    s2_next.b_msb         = s1.b_msb;
  end

  logic [WIDTH-1:0] g_final;
  if (SPLIT == LEVELS) begin : g_all_in_stage2
    assign g_final = s2.g[WIDTH-1:0];
  end else begin : g_tail_in_stage3
    assign g_final = lvl_g[LEVELS];
  end

  logic [WIDTH-1:0] sum;
  logic             carry_out;
  assign sum       = s2.p0[WIDTH-1:0] ^ {g_final[WIDTH-2:0], s2.c0};
  assign carry_out = g_final[WIDTH-1];

  logic unused_bits;
  assign unused_bits = ^{s1, s2, lvl_g[LEVELS], lvl_p[LEVELS]};

  // Data only loads with a valid token, so bubbles never disturb the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      s1    <= '0;
      s2    <= '0;
      diff  <= '0;
      b_out <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
      if (en1 && in_valid) s1 <= s1_next;
      if (en2 && v1)       s2 <= s2_next;
      if (en3 && v2) begin
        diff  <= sum;
        b_out <= ~carry_out;
        ovf   <= (s2.a_msb ^ s2.b_msb) & (s2.a_msb ^ sum[WIDTH-1]);
        zero  <= ~|sum;
      end
    end
  end

endmodule
